stage_id: RTL and testbench
===========================

Name: stage_id

Overview:
- Decode stage, directly downstream of instruction fetch.
- Holds the IF/ID pipeline register and the 32x32 register file with a write-back port and write-through bypass.
- Performs load-use hazard detection: on a hazard it stalls fetch and inserts a bubble.
- Drives the registered ID/EX outputs consumed by execute.
- Branch-taken from EX/MEM flushes the instruction held in decode.

Parameters:
- NOP_INST, 32'h00000000, instruction word loaded into IF/ID on reset or flush.
- LOAD_OPCODE, 6'b100011, opcode (Inst[31:26]) identifying a load for hazard detection.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clock.
- IF_PC  in  32  PC of the fetched instruction (word-addressed).
- IF_PC4  in  32  next sequential PC (IF_PC+1).
- IF_Inst  in  32  fetched instruction word.
- IF_InstNum  in  4  instruction sequence tag.
- IF_InstType  in  4  instruction class tag.
- CS_Branch  in  1  branch taken (from EX/MEM); flush request.
- WB_RegWrite  in  1  write-back enable.
- WB_WriteReg  in  5  write-back destination register.
- WB_WriteData  in  32  write-back data.
- Stall_IF  out  1  combinational; 1 = fetch must hold PC and not advance.
- EndStageID_PC  out  32  ID/EX PC.
- EndStageID_PC4  out  32  ID/EX PC+1.
- EndStageID_RsData  out  32  rs operand.
- EndStageID_RtData  out  32  rt operand.
- EndStageID_Imm  out  32  sign-extended Inst[15:0].
- EndStageID_Rs  out  5  Inst[25:21].
- EndStageID_Rt  out  5  Inst[20:16].
- EndStageID_Rd  out  5  Inst[15:11].
- EndStageID_Opcode  out  6  Inst[31:26].
- EndStageID_Funct  out  6  Inst[5:0].
- EndStageID_MemRead  out  1  1 if opcode==LOAD_OPCODE and valid.
- EndStageID_InstNum  out  4  tag passthrough.
- EndStageID_InstType  out  4  tag passthrough.
- EndStageID_Valid  out  1  0 = bubble.

Behaviour:
- Reset (reset==0 at posedge):
  - IF/ID: Inst=NOP_INST, valid=0; PC, PC4 and tags = 0.
  - All 32 register-file entries = 0.
  - All EndStageID_* outputs = 0.
  - Stall_IF = 0 while the ID/EX register is reset.
  - Reset mid-stall or mid-flush overrides everything.
- Pipeline: an instruction captured into IF/ID at edge N appears on EndStageID_* after edge N+1. Latency is 1 cycle in decode.
- Register file:
  - Write at posedge when WB_RegWrite=1 and WB_WriteReg!=0. Register 0 always reads 0, and writes to it are ignored.
  - Read is combinational from IF/ID Inst fields.
  - Bypass: if WB_RegWrite=1, WB_WriteReg!=0 and WB_WriteReg equals the read address, the read returns WB_WriteData in the same cycle.
- Hazard (combinational): hazard = EndStageID_Valid & EndStageID_MemRead & IFID_valid & (EndStageID_Rt!=0) & (EndStageID_Rt==IFID_Rs | EndStageID_Rt==IFID_Rt).
- Stall_IF = hazard & ~CS_Branch.
- Priority at each posedge, reset > flush > stall > normal:
  - Flush (CS_Branch=1): IF/ID loads NOP_INST with valid=0; the ID/EX register loads a bubble (all fields 0, Valid=0). The stall is ignored.
  - Stall: IF/ID holds its contents; the ID/EX register loads a bubble. A stall lasts exactly 1 cycle per load-use pair, because the bubble clears the hazard.
  - Normal: IF/ID captures the IF_* inputs with valid=1; ID/EX captures the decoded IF/ID contents, and Valid is copied from IF/ID valid.
- Arithmetic and widths:
  - Imm = {{16{Inst[15]}}, Inst[15:0]}.
  - No arithmetic on PC; PC4 is passed through unchanged.
- Register-file writes happen regardless of stall or flush; the write-back port is independent.

Test Plan:
- Reset: hold reset=0 for 2 cycles with arbitrary IF_* inputs -> all EndStageID_* = 0, Stall_IF=0; a read of r5 after reset returns 0.
- Normal flow: after write-back of r3=32'h0000_1234, feed Inst=32'h0003_2020 (rs=0, rt=3, rd=4) at PC=8 -> one edge later EndStageID_RtData=32'h1234, Rd=4, PC4=9, Valid=1.
- Bypass and r0: in the same cycle, WB writes r7=32'hDEAD_BEEF while decoding rs=7 -> RsData=32'hDEADBEEF. A WB write to r0 of 32'hFFFF_FFFF, then read r0 -> 0.
- Load-use: LW with rt=2 (Inst=32'h8C02_0000) followed by an instruction with rs=2 -> Stall_IF=1 for exactly 1 cycle; the next ID/EX output is a bubble (Valid=0); the dependent instruction then emerges with Valid=1. No stall when LW rt=0.
- Flush: CS_Branch=1 while the fetched instruction sits in IF/ID -> the next two ID/EX outputs have Valid=0.
- Flush during stall: hazard and CS_Branch=1 together -> Stall_IF=0 and IF/ID is flushed.

Source files
------------

// File: rtl/stage_id.sv
// Decode stage: IF/ID register, 32x32 register file with write-through bypass,
// load-use hazard detection and the registered ID/EX outputs feeding execute.
module stage_id #(
  parameter logic [31:0] NOP_INST    = 32'h0000_0000,
  parameter logic [5:0]  LOAD_OPCODE = 6'b100011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_PC4,
  input  logic [31:0] IF_Inst,
  input  logic [3:0]  IF_InstNum,
  input  logic [3:0]  IF_InstType,
  input  logic        CS_Branch,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_WriteData,
  output logic        Stall_IF,
  output logic [31:0] EndStageID_PC,
  output logic [31:0] EndStageID_PC4,
  output logic [31:0] EndStageID_RsData,
  output logic [31:0] EndStageID_RtData,
  output logic [31:0] EndStageID_Imm,
  output logic [4:0]  EndStageID_Rs,
  output logic [4:0]  EndStageID_Rt,
  output logic [4:0]  EndStageID_Rd,
  output logic [5:0]  EndStageID_Opcode,
  output logic [5:0]  EndStageID_Funct,
  output logic        EndStageID_MemRead,
  output logic [3:0]  EndStageID_InstNum,
  output logic [3:0]  EndStageID_InstType,
  output logic        EndStageID_Valid
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned TW   = 4;
  localparam int unsigned OPW  = 6;

  // IF/ID pipeline register
  logic [XLEN-1:0] ifid_inst_q, ifid_inst_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [TW-1:0]   ifid_num_q, ifid_num_d;
  logic [TW-1:0]   ifid_type_q, ifid_type_d;
  logic            ifid_valid_q, ifid_valid_d;

  // ID/EX pipeline register
  logic [XLEN-1:0] idex_pc_q, idex_pc_d;
  logic [XLEN-1:0] idex_pc4_q, idex_pc4_d;
  logic [XLEN-1:0] idex_rsd_q, idex_rsd_d;
  logic [XLEN-1:0] idex_rtd_q, idex_rtd_d;
  logic [XLEN-1:0] idex_imm_q, idex_imm_d;
  logic [RW-1:0]   idex_rs_q, idex_rs_d;
  logic [RW-1:0]   idex_rt_q, idex_rt_d;
  logic [RW-1:0]   idex_rd_q, idex_rd_d;
  logic [OPW-1:0]  idex_op_q, idex_op_d;
  logic [OPW-1:0]  idex_fn_q, idex_fn_d;
  logic            idex_mr_q, idex_mr_d;
  logic [TW-1:0]   idex_num_q, idex_num_d;
  logic [TW-1:0]   idex_type_q, idex_type_d;
  logic            idex_valid_q, idex_valid_d;

  logic [XLEN-1:0] rf_q [NREG];

  logic [RW-1:0]   dec_rs, dec_rt;
  logic [XLEN-1:0] rs_data, rt_data;
  logic            hazard;
  logic            wb_en;

  assign dec_rs = ifid_inst_q[25:21];
  assign dec_rt = ifid_inst_q[20:16];
  assign wb_en  = WB_RegWrite && (WB_WriteReg != RW'(0));

  // Operand read: r0 is hard zero, same-cycle write-back bypasses the array
  always_comb begin
    rs_data = rf_q[dec_rs];
    rt_data = rf_q[dec_rt];
    if (wb_en && (WB_WriteReg == dec_rs)) rs_data = WB_WriteData;
    if (wb_en && (WB_WriteReg == dec_rt)) rt_data = WB_WriteData;
    if (dec_rs == RW'(0)) rs_data = '0;
    if (dec_rt == RW'(0)) rt_data = '0;
  end

  // Load-use hazard between the load in ID/EX and the consumer in IF/ID
  always_comb begin
    hazard = idex_valid_q & idex_mr_q & ifid_valid_q & (idex_rt_q != RW'(0)) &
             ((idex_rt_q == dec_rs) | (idex_rt_q == dec_rt));
  end

  assign Stall_IF = hazard & ~CS_Branch;

  // Next-state selection: flush > stall > normal; ID/EX defaults to a bubble
  always_comb begin
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_num_d   = ifid_num_q;
    ifid_type_d  = ifid_type_q;
    ifid_valid_d = ifid_valid_q;
    idex_pc_d    = '0;
    idex_pc4_d   = '0;
    idex_rsd_d   = '0;
    idex_rtd_d   = '0;
    idex_imm_d   = '0;
    idex_rs_d    = '0;
    idex_rt_d    = '0;
    idex_rd_d    = '0;
    idex_op_d    = '0;
    idex_fn_d    = '0;
    idex_mr_d    = 1'b0;
    idex_num_d   = '0;
    idex_type_d  = '0;
    idex_valid_d = 1'b0;
    if (CS_Branch) begin
      ifid_inst_d  = NOP_INST;
      ifid_pc_d    = '0;
      ifid_pc4_d   = '0;
      ifid_num_d   = '0;
      ifid_type_d  = '0;
      ifid_valid_d = 1'b0;
    end else if (!hazard) begin
      ifid_inst_d  = IF_Inst;
      ifid_pc_d    = IF_PC;
      ifid_pc4_d   = IF_PC4;
      ifid_num_d   = IF_InstNum;
      ifid_type_d  = IF_InstType;
      ifid_valid_d = 1'b1;
      idex_pc_d    = ifid_pc_q;
      idex_pc4_d   = ifid_pc4_q;
      idex_rsd_d   = rs_data;
      idex_rtd_d   = rt_data;
      idex_imm_d   = {{16{ifid_inst_q[15]}}, ifid_inst_q[15:0]};
      idex_rs_d    = dec_rs;
      idex_rt_d    = dec_rt;
      idex_rd_d    = ifid_inst_q[15:11];
      idex_op_d    = ifid_inst_q[31:26];
      idex_fn_d    = ifid_inst_q[5:0];
      idex_mr_d    = (ifid_inst_q[31:26] == LOAD_OPCODE) & ifid_valid_q;
      idex_num_d   = ifid_num_q;
      idex_type_d  = ifid_type_q;
      idex_valid_d = ifid_valid_q;
    end
  end

  // Pipeline registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      ifid_inst_q  <= NOP_INST;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_num_q   <= '0;
      ifid_type_q  <= '0;
      ifid_valid_q <= 1'b0;
      idex_pc_q    <= '0;
      idex_pc4_q   <= '0;
      idex_rsd_q   <= '0;
      idex_rtd_q   <= '0;
      idex_imm_q   <= '0;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_rd_q    <= '0;
      idex_op_q    <= '0;
      idex_fn_q    <= '0;
      idex_mr_q    <= 1'b0;
      idex_num_q   <= '0;
      idex_type_q  <= '0;
      idex_valid_q <= 1'b0;
    end else begin
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_num_q   <= ifid_num_d;
      ifid_type_q  <= ifid_type_d;
      ifid_valid_q <= ifid_valid_d;
      idex_pc_q    <= idex_pc_d;
      idex_pc4_q   <= idex_pc4_d;
      idex_rsd_q   <= idex_rsd_d;
      idex_rtd_q   <= idex_rtd_d;
      idex_imm_q   <= idex_imm_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      idex_op_q    <= idex_op_d;
      idex_fn_q    <= idex_fn_d;
      idex_mr_q    <= idex_mr_d;
      idex_num_q   <= idex_num_d;
      idex_type_q  <= idex_type_d;
      idex_valid_q <= idex_valid_d;
    end
  end

  // Register file write port, independent of stall and flush
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[WB_WriteReg] <= WB_WriteData;
    end
  end

  assign EndStageID_PC       = idex_pc_q;
  assign EndStageID_PC4      = idex_pc4_q;
  assign EndStageID_RsData   = idex_rsd_q;
  assign EndStageID_RtData   = idex_rtd_q;
  assign EndStageID_Imm      = idex_imm_q;
  assign EndStageID_Rs       = idex_rs_q;
  assign EndStageID_Rt       = idex_rt_q;
  assign EndStageID_Rd       = idex_rd_q;
  assign EndStageID_Opcode   = idex_op_q;
  assign EndStageID_Funct    = idex_fn_q;
  assign EndStageID_MemRead  = idex_mr_q;
  assign EndStageID_InstNum  = idex_num_q;
  assign EndStageID_InstType = idex_type_q;
  assign EndStageID_Valid    = idex_valid_q;

endmodule

// File: tb/tb_stage_id.sv
// Directed bench for stage_id: expected ID/EX words queued at fetch, compared at output.
module tb_stage_id;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IF_PC, IF_PC4, IF_Inst;
  logic [3:0]  IF_InstNum, IF_InstType;
  logic        CS_Branch;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic        Stall_IF;
  logic [31:0] EndStageID_PC, EndStageID_PC4, EndStageID_RsData, EndStageID_RtData, EndStageID_Imm;
  logic [4:0]  EndStageID_Rs, EndStageID_Rt, EndStageID_Rd;
  logic [5:0]  EndStageID_Opcode, EndStageID_Funct;
  logic        EndStageID_MemRead;
  logic [3:0]  EndStageID_InstNum, EndStageID_InstType;
  logic        EndStageID_Valid;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        mr;
    logic [3:0]  num;
    logic [3:0]  typ;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  stage_id dut (
    .clock(clock), .reset(reset),
    .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_Inst(IF_Inst),
    .IF_InstNum(IF_InstNum), .IF_InstType(IF_InstType),
    .CS_Branch(CS_Branch),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .Stall_IF(Stall_IF),
    .EndStageID_PC(EndStageID_PC), .EndStageID_PC4(EndStageID_PC4),
    .EndStageID_RsData(EndStageID_RsData), .EndStageID_RtData(EndStageID_RtData),
    .EndStageID_Imm(EndStageID_Imm),
    .EndStageID_Rs(EndStageID_Rs), .EndStageID_Rt(EndStageID_Rt), .EndStageID_Rd(EndStageID_Rd),
    .EndStageID_Opcode(EndStageID_Opcode), .EndStageID_Funct(EndStageID_Funct),
    .EndStageID_MemRead(EndStageID_MemRead),
    .EndStageID_InstNum(EndStageID_InstNum), .EndStageID_InstType(EndStageID_InstType),
    .EndStageID_Valid(EndStageID_Valid)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic [3:0] num,
                              input logic [3:0] typ, input logic [31:0] rsd,
                              input logic [31:0] rtd);
    exp_t e;
    e.valid = 1'b1;
    e.pc    = pc;
    e.pc4   = pc4;
    e.rsd   = rsd;
    e.rtd   = rtd;
    e.imm   = inst[15] ? {16'hFFFF, inst[15:0]} : {16'h0000, inst[15:0]};
    e.rs    = inst[25:21];
    e.rt    = inst[20:16];
    e.rd    = inst[15:11];
    e.op    = inst[31:26];
    e.fn    = inst[5:0];
    e.mr    = (inst[31:26] == 6'h23);
    e.num   = num;
    e.typ   = typ;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    check({tag, ".valid"}, 32'(EndStageID_Valid), 32'(e.valid));
    check({tag, ".pc"}, EndStageID_PC, e.pc);
    check({tag, ".pc4"}, EndStageID_PC4, e.pc4);
    check({tag, ".rsdata"}, EndStageID_RsData, e.rsd);
    check({tag, ".rtdata"}, EndStageID_RtData, e.rtd);
    check({tag, ".imm"}, EndStageID_Imm, e.imm);
    check({tag, ".fields"},
          32'({EndStageID_Rs, EndStageID_Rt, EndStageID_Rd, EndStageID_Opcode, EndStageID_Funct}),
          32'({e.rs, e.rt, e.rd, e.op, e.fn}));
    check({tag, ".memread"}, 32'(EndStageID_MemRead), 32'(e.mr));
    check({tag, ".tags"}, 32'({EndStageID_InstNum, EndStageID_InstType}), 32'({e.num, e.typ}));
  endtask

  // One clock edge, then compare the ID/EX word against the scoreboard head
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed valid %0b expected an entry", tag, EndStageID_Valid);
    end else begin
      e = sb.pop_front();
      cmp_out(tag, e);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pc4,
                       input logic [3:0] num, input logic [3:0] typ);
    IF_Inst     = inst;
    IF_PC       = pc;
    IF_PC4      = pc4;
    IF_InstNum  = num;
    IF_InstType = typ;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    WB_RegWrite  = en;
    WB_WriteReg  = r;
    WB_WriteData = d;
  endtask

  initial begin
    reset     = 1'b0;
    CS_Branch = 1'b0;
    drive($urandom, $urandom, $urandom, 4'($urandom), 4'($urandom));
    wb(1'b1, 5'd5, 32'hCAFE_F00D);
    @(posedge clock);
    #1;
    drive(32'h8C02_0000, $urandom, $urandom, 4'($urandom), 4'($urandom));
    @(posedge clock);
    #1;
    cmp_out("reset", '0);
    check("reset.stall", 32'(Stall_IF), 32'd0);

    // Release reset; the first output is the reset-state IF/ID bubble
    sb.push_back('0);
    reset = 1'b1;
    wb(1'b1, 5'd3, 32'h0000_1234);
    drive(32'h00A0_0000, 32'd4, 32'd5, 4'd1, 4'd2);
    sb.push_back(mk(32'h00A0_0000, 32'd4, 32'd5, 4'd1, 4'd2, 32'd0, 32'd0));
    tick("c1");

    wb(1'b0, 5'd0, 32'd0);
    drive(32'h0003_2020, 32'd8, 32'd9, 4'd2, 4'd1);
    sb.push_back(mk(32'h0003_2020, 32'd8, 32'd9, 4'd2, 4'd1, 32'd0, 32'h0000_1234));
    tick("r5_after_reset");

    drive(32'h00E0_8001, 32'd12, 32'd13, 4'd3, 4'd3);
    sb.push_back(mk(32'h00E0_8001, 32'd12, 32'd13, 4'd3, 4'd3, 32'hDEAD_BEEF, 32'd0));
    tick("normal");

    wb(1'b1, 5'd7, 32'hDEAD_BEEF);
    drive(32'h0007_0000, 32'd16, 32'd17, 4'd4, 4'd1);
    sb.push_back(mk(32'h0007_0000, 32'd16, 32'd17, 4'd4, 4'd1, 32'd0, 32'hDEAD_BEEF));
    tick("bypass");

    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    drive(32'h0000_0000, 32'd20, 32'd21, 4'd5, 4'd1);
    sb.push_back(mk(32'h0000_0000, 32'd20, 32'd21, 4'd5, 4'd1, 32'd0, 32'd0));
    tick("r7_array");

    wb(1'b1, 5'd2, 32'h0000_5555);
    drive(32'h8C02_0000, 32'd24, 32'd25, 4'd6, 4'd4);
    sb.push_back(mk(32'h8C02_0000, 32'd24, 32'd25, 4'd6, 4'd4, 32'd0, 32'h0000_5555));
    tick("r0_after_write");
    check("no_stall_before_lw", 32'(Stall_IF), 32'd0);

    // Load-use: dependent rs=2 behind LW rt=2
    wb(1'b0, 5'd0, 32'd0);
    drive(32'h0040_0000, 32'd28, 32'd29, 4'd7, 4'd1);
    sb.push_back(mk(32'h0040_0000, 32'd28, 32'd29, 4'd7, 4'd1, 32'h0000_5555, 32'd0));
    tick("lw_out");
    check("load_use_stall", 32'(Stall_IF), 32'd1);

    sb.push_front('0);
    tick("stall_bubble");
    check("stall_one_cycle", 32'(Stall_IF), 32'd0);

    drive(32'h8C00_0000, 32'd32, 32'd33, 4'd8, 4'd4);
    sb.push_back(mk(32'h8C00_0000, 32'd32, 32'd33, 4'd8, 4'd4, 32'd0, 32'd0));
    tick("dependent_out");

    drive(32'h0000_2020, 32'd36, 32'd37, 4'd9, 4'd1);
    sb.push_back(mk(32'h0000_2020, 32'd36, 32'd37, 4'd9, 4'd1, 32'd0, 32'd0));
    tick("lw_rt0_out");
    check("no_stall_lw_rt0", 32'(Stall_IF), 32'd0);

    // Flush of the instruction held in IF/ID
    drive(32'h0123_4567, 32'd40, 32'd41, 4'd10, 4'd2);
    sb.push_back(mk(32'h0123_4567, 32'd40, 32'd41, 4'd10, 4'd2, 32'd0, 32'h0000_1234));
    tick("pre_flush");

    CS_Branch = 1'b1;
    void'(sb.pop_front());
    sb.push_front('0);
    drive(32'h0060_0000, 32'd44, 32'd45, 4'd11, 4'd2);
    sb.push_back('0);
    tick("flush_bubble1");

    CS_Branch = 1'b0;
    drive(32'h0000_1820, 32'd48, 32'd49, 4'd12, 4'd1);
    sb.push_back(mk(32'h0000_1820, 32'd48, 32'd49, 4'd12, 4'd1, 32'd0, 32'd0));
    tick("flush_bubble2");

    // Flush arriving together with a load-use hazard
    drive(32'h8C02_0000, 32'd52, 32'd53, 4'd13, 4'd4);
    sb.push_back(mk(32'h8C02_0000, 32'd52, 32'd53, 4'd13, 4'd4, 32'd0, 32'h0000_5555));
    tick("after_flush");

    drive(32'h0002_0000, 32'd56, 32'd57, 4'd14, 4'd1);
    sb.push_back(mk(32'h0002_0000, 32'd56, 32'd57, 4'd14, 4'd1, 32'd0, 32'h0000_5555));
    tick("lw2_out");
    check("load_use_stall_rt", 32'(Stall_IF), 32'd1);

    CS_Branch = 1'b1;
    #1;
    check("flush_masks_stall", 32'(Stall_IF), 32'd0);
    void'(sb.pop_front());
    sb.push_front('0);
    drive(32'h0080_0000, 32'd60, 32'd61, 4'd15, 4'd2);
    sb.push_back('0);
    tick("flush_stall_bubble1");

    CS_Branch = 1'b0;
    drive(32'h0000_2820, 32'd64, 32'd65, 4'd0, 4'd1);
    sb.push_back(mk(32'h0000_2820, 32'd64, 32'd65, 4'd0, 4'd1, 32'd0, 32'd0));
    tick("flush_stall_bubble2");
    check("post_flush_no_stall", 32'(Stall_IF), 32'd0);

    drive(32'h0000_0000, 32'd68, 32'd69, 4'd1, 4'd0);
    sb.push_back(mk(32'h0000_0000, 32'd68, 32'd69, 4'd1, 4'd0, 32'd0, 32'd0));
    tick("resume");

    // Reset mid-flow with a flush request pending
    reset     = 1'b0;
    CS_Branch = 1'b1;
    @(posedge clock);
    #1;
    cmp_out("mid_reset", '0);
    check("mid_reset.stall", 32'(Stall_IF), 32'd0);
    sb.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
